prod_accum: RTL and testbench
=============================

// Module: prod_accum
// PURPOSE
//   Sequential accumulator stage directly downstream of the 4x4 unsigned multiplier.
//   Takes one 8-bit product per beat ({Cout,Z[6:0]}) over a valid/ready handshake and sums a frame of products.
//   A frame ends on in_last or after MAX_TERMS beats; the total is then offered on a registered result port.
//   Used for dot-product / MAC datapaths built around the multiplier.
// PARAMETERS
//   PROD_W     8   width of the incoming product ({Cout,Z}); fixed by the multiplier, not meant to change
//   ACC_W      12  accumulator/result width; the 12-bit default holds 16 x 225 = 3600 without overflow
//   MAX_TERMS  16  max beats per frame; the frame closes automatically on beat MAX_TERMS
// PORTS
//   clk        in   1                   single clock, rising edge
//   rst_n      in   1                   synchronous, active-low reset
//   clr        in   1                   synchronous frame abort; discards the partial sum and any pending result
//   in_prod    in   PROD_W              product from the multiplier, {Cout,Z}
//   in_valid   in   1                   in_prod/in_last are valid
//   in_last    in   1                   this beat closes the frame
//   in_ready   out  1                   stage accepts a beat this cycle
//   res_data   out  ACC_W               frame sum (registered)
//   res_count  out  $clog2(MAX_TERMS+1) number of beats in the frame
//   res_ovf    out  1                   sum exceeded 2^ACC_W-1 at some point in the frame (res_data wrapped)
//   res_valid  out  1                   result is held stable
//   res_ready  in   1                   consumer takes the result
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge): state=S_ACC; acc, cnt and ovf cleared.
//     Outputs after reset: res_data=0, res_count=0, res_ovf=0, res_valid=0, in_ready=1.
//   FSM has two states: S_ACC and S_OUT.
//   in_ready = (state==S_ACC) && !clr. A beat is accepted when in_valid && in_ready.
//   S_ACC, on an accepted beat:
//     - acc <= acc + zero-extended in_prod, computed at ACC_W+1 bits.
//     - If bit ACC_W of that sum is set, ovf becomes sticky 1 and acc keeps the low ACC_W bits (wraps).
//     - cnt <= cnt + 1.
//   Frame close: an accepted beat with in_last=1, or with cnt==MAX_TERMS-1.
//     - res_data/res_count/res_ovf load the post-add values, including this beat.
//     - res_valid<=1; acc, cnt and ovf clear; state->S_OUT.
//     - Latency: the result is visible the cycle after the closing beat.
//   S_OUT: in_ready=0; res_* are held stable.
//     - On res_valid && res_ready: res_valid<=0, state->S_ACC.
//     - A beat can be accepted again on the following cycle (1 bubble per frame).
//   in_last on the MAX_TERMS-th beat is one close, not two.
//   in_valid with no in_last, and no close: keep accumulating; no timeout.
//   Zero-beat frames do not exist; a frame needs at least one accepted beat.
//   clr=1: priority over everything except rst_n.
//     - acc, cnt and ovf clear; res_valid<=0; state->S_ACC.
//     - res_data, res_count and res_ovf keep their last values.
//     - No beat is accepted in a clr cycle.
//   rst_n mid-frame or in S_OUT: the partial sum and the pending result are lost; no result is emitted.
//   Inputs are not registered; res_* come straight from flops with no combinational path from in_*.
// STRUCTURE
//   State encodings (S_ACC=1'b0, S_OUT=1'b1) and PROD_W go in the shared multiplier defines header as localparams.
//   No sub-module; the adder is behavioural at ACC_W+1 bits.
//   The top level may instance this stage behind the multiplier, with the multiplier's {Cout,Z} wired to in_prod.
// TESTING
//   1. Reset: rst_n=0 for 2 cycles -> res_valid=0, res_data=0, in_ready=1.
//   2. Beats 3, 5, 7; last on 7; res_ready=1 -> cycle after 7: res_data=15, res_count=3, res_ovf=0; in_ready=0 for exactly 1 cycle.
//   3. 16 beats of 225 (15x15), no in_last -> auto close: res_data=3600, res_count=16, res_ovf=0.
//   4. ACC_W=10, 5 beats of 225 with last on beat 5 -> res_data=101 (1125-1024), res_ovf=1.
//   5. Backpressure: result 42 pending, res_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 throughout.
//      res_data holds 42; no beat is lost; the next frame starts after the handshake.
//   6. clr after beats 10, 20 -> no result emitted; next frame of beat 4 with last -> res_data=4, res_count=1.
//      Repeat with rst_n=0 instead of clr -> same outcome.

Source files
------------

// File: rtl/prod_accum_pkg.sv
// Shared definitions for the product accumulator stage that sits behind
// the 4x4 multiplier: FSM state encodings and the fixed product width.
package prod_accum_pkg;

  // Width of the multiplier result {Cout, Z[6:0]}; set by the multiplier itself.
  localparam int PROD_W = 8;

  // Accumulator FSM: collecting beats, or holding a finished frame result.
  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_e;

endpackage

// File: rtl/prod_accum.sv
// Frame accumulator: sums the products arriving over a valid/ready handshake
// and presents the frame total, beat count and overflow flag on a registered
// result port. A frame closes on in_last or on its MAX_TERMS-th beat.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int ACC_W     = 12,
  parameter int MAX_TERMS = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic [PROD_W-1:0]                in_prod,
  input  logic                             in_valid,
  input  logic                             in_last,
  output logic                             in_ready,
  output logic [ACC_W-1:0]                 res_data,
  output logic [$clog2(MAX_TERMS+1)-1:0]   res_count,
  output logic                             res_ovf,
  output logic                             res_valid,
  input  logic                             res_ready
);

  localparam int CNT_W = $clog2(MAX_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_TERMS - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] res_data_q, res_data_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic             res_ovf_q, res_ovf_d;
  logic             res_valid_q, res_valid_d;

  logic             accept;
  logic             close;
  logic [ACC_W:0]   sum;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_new;

  // A beat is taken only while collecting and not being aborted.
  assign in_ready = (state_q == S_ACC) && !clr;
  assign accept   = in_valid && in_ready;

  // One extra adder bit exposes the carry used as the sticky overflow source.
  assign sum      = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
  assign cnt_inc  = cnt_q + 1'b1;
  assign ovf_new  = ovf_q | sum[ACC_W];
  assign close    = in_last || (cnt_q == LAST_CNT);

  // Next-state logic: clr dominates; otherwise accumulate, close, or wait for the consumer.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    res_data_d  = res_data_q;
    res_count_d = res_count_q;
    res_ovf_d   = res_ovf_q;
    res_valid_d = res_valid_q;

    if (clr) begin
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      res_valid_d = 1'b0;
      state_d     = S_ACC;
    end else begin
      case (state_q)
        S_ACC: begin
          if (accept) begin
            if (close) begin
              res_data_d  = sum[ACC_W-1:0];
              res_count_d = cnt_inc;
              res_ovf_d   = ovf_new;
              res_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = '0;
              ovf_d       = 1'b0;
              state_d     = S_OUT;
            end else begin
              acc_d = sum[ACC_W-1:0];
              cnt_d = cnt_inc;
              ovf_d = ovf_new;
            end
          end
        end
        S_OUT: begin
          if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
            state_d     = S_ACC;
          end
        end
        default: state_d = S_ACC;
      endcase
    end
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      res_data_q  <= '0;
      res_count_q <= '0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign res_data  = res_data_q;
  assign res_count = res_count_q;
  assign res_ovf   = res_ovf_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_prod_accum.sv
// Self-checking bench for prod_accum. Two instances (12-bit and 10-bit
// accumulators) share the same stimulus; a frame-level reference model
// predicts handshake and result values from plain integer totals.
module tb_prod_accum;

  logic        clk = 1'b0;
  logic        rstN;
  logic        clr;
  logic [7:0]  inProd;
  logic        inValid;
  logic        inLast;
  logic        resReady;

  logic        inReady, inReady10;
  logic [11:0] resData;
  logic [9:0]  resData10;
  logic [4:0]  resCount, resCount10;
  logic        resOvf, resOvf10;
  logic        resValid, resValid10;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state: running frame total/count and the pending result.
  int total = 0;
  int count = 0;
  bit pending = 0;
  int expData12 = 0, expData10 = 0, expCount = 0;
  bit expOvf12 = 0, expOvf10 = 0;
  bit lastAccepted = 0;

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  prod_accum #(.ACC_W(12), .MAX_TERMS(16)) dut (
    .clk(clk), .rst_n(rstN), .clr(clr), .in_prod(inProd), .in_valid(inValid),
    .in_last(inLast), .in_ready(inReady), .res_data(resData), .res_count(resCount),
    .res_ovf(resOvf), .res_valid(resValid), .res_ready(resReady)
  );

  prod_accum #(.ACC_W(10), .MAX_TERMS(16)) dut10 (
    .clk(clk), .rst_n(rstN), .clr(clr), .in_prod(inProd), .in_valid(inValid),
    .in_last(inLast), .in_ready(inReady10), .res_data(resData10), .res_count(resCount10),
    .res_ovf(resOvf10), .res_valid(resValid10), .res_ready(resReady)
  );

  // Single comparison point: count it, report any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Compare all outputs to the model, advance the model by one clock, then cross the edge.
  task automatic stepCycle();
    #1;
    checkOutput("in_ready", inReady, !pending && !clr);
    checkOutput("in_ready10", inReady10, !pending && !clr);
    checkOutput("res_valid", resValid, pending);
    checkOutput("res_valid10", resValid10, pending);
    checkOutput("res_data", resData, expData12);
    checkOutput("res_data10", resData10, expData10);
    checkOutput("res_count", resCount, expCount);
    checkOutput("res_count10", resCount10, expCount);
    checkOutput("res_ovf", resOvf, expOvf12);
    checkOutput("res_ovf10", resOvf10, expOvf10);

    lastAccepted = 0;
    if (!rstN) begin
      total = 0; count = 0; pending = 0;
      expData12 = 0; expData10 = 0; expCount = 0; expOvf12 = 0; expOvf10 = 0;
    end else if (clr) begin
      total = 0; count = 0; pending = 0;
    end else if (pending) begin
      if (resReady) pending = 0;
    end else if (inValid) begin
      lastAccepted = 1;
      total += int'(inProd);
      count++;
      if (inLast || count == 16) begin
        expData12 = total % 4096;
        expData10 = total % 1024;
        expOvf12  = (total >= 4096);
        expOvf10  = (total >= 1024);
        expCount  = count;
        pending   = 1;
        total = 0; count = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until the stage takes it (bounded wait).
  task automatic applyStimulus(input logic [7:0] prod, input logic last);
    int tries = 0;
    inProd  = prod;
    inLast  = last;
    inValid = 1'b1;
    do begin
      stepCycle();
      tries++;
    end while (!lastAccepted && tries < 30);
    if (!lastAccepted) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL beat_timeout: got not accepted, expected accepted within 30 cycles");
    end
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  initial begin
    rstN = 1'b0; clr = 1'b0; inProd = '0; inValid = 1'b0; inLast = 1'b0; resReady = 1'b1;

    // Reset held for two edges, then the idle state is checked by stepCycle.
    @(posedge clk);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    idle(2);
    checkOutput("t1_res_data", resData, 0);

    // Small frame 3+5+7 closed by in_last.
    applyStimulus(8'd3, 1'b0);
    applyStimulus(8'd5, 1'b0);
    applyStimulus(8'd7, 1'b1);
    checkOutput("t2_data", resData, 15);
    checkOutput("t2_count", resCount, 3);
    checkOutput("t2_ovf", resOvf, 0);
    checkOutput("t2_ready_low", inReady, 0);
    idle(1);
    checkOutput("t2_ready_back", inReady, 1);

    // Sixteen full-scale products, closed by the beat limit.
    for (int i = 0; i < 16; i++) applyStimulus(8'd225, 1'b0);
    checkOutput("t3_data", resData, 3600);
    checkOutput("t3_count", resCount, 16);
    checkOutput("t3_ovf", resOvf, 0);
    checkOutput("t3_data10", resData10, 528);
    checkOutput("t3_ovf10", resOvf10, 1);
    idle(1);

    // Five full-scale products: wraps the 10-bit accumulator.
    for (int i = 0; i < 5; i++) applyStimulus(8'd225, i == 4);
    checkOutput("t4_data10", resData10, 101);
    checkOutput("t4_ovf10", resOvf10, 1);
    checkOutput("t4_count10", resCount10, 5);
    checkOutput("t4_data", resData, 1125);
    idle(1);

    // Backpressure: result 42 held while the next beat waits.
    resReady = 1'b0;
    applyStimulus(8'd40, 1'b0);
    applyStimulus(8'd2, 1'b1);
    inProd = 8'd9; inLast = 1'b1; inValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput("t5_no_accept", lastAccepted, 0);
      checkOutput("t5_hold", resData, 42);
    end
    resReady = 1'b1;
    applyStimulus(8'd9, 1'b1);
    checkOutput("t5_next_data", resData, 9);
    checkOutput("t5_next_count", resCount, 1);
    idle(1);

    // Abort a partial frame with clr, then with reset.
    applyStimulus(8'd10, 1'b0);
    applyStimulus(8'd20, 1'b0);
    clr = 1'b1; inValid = 1'b1; inProd = 8'd99;
    stepCycle();
    checkOutput("t6_clr_no_accept", lastAccepted, 0);
    clr = 1'b0; inValid = 1'b0;
    idle(1);
    checkOutput("t6_clr_no_result", resValid, 0);
    applyStimulus(8'd4, 1'b1);
    checkOutput("t6_clr_data", resData, 4);
    checkOutput("t6_clr_count", resCount, 1);
    idle(1);
    applyStimulus(8'd10, 1'b0);
    applyStimulus(8'd20, 1'b0);
    rstN = 1'b0;
    stepCycle();
    rstN = 1'b1;
    idle(1);
    checkOutput("t6_rst_no_result", resValid, 0);
    applyStimulus(8'd4, 1'b1);
    checkOutput("t6_rst_data", resData, 4);
    checkOutput("t6_rst_count", resCount, 1);
    idle(1);

    // Randomized traffic with random backpressure, aborts and resets.
    for (int i = 0; i < 800; i++) begin
      inValid  = ($urandom_range(0, 3) != 0);
      inProd   = ($urandom_range(0, 3) == 0) ? 8'd225 : 8'($urandom_range(0, 255));
      inLast   = ($urandom_range(0, 7) == 0);
      resReady = ($urandom_range(0, 2) != 0);
      clr      = ($urandom_range(0, 40) == 0);
      rstN     = ($urandom_range(0, 100) != 0);
      stepCycle();
    end
    clr = 1'b0; rstN = 1'b1; inValid = 1'b0; resReady = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
